// File: rtl/bram_fifo_ctrl.sv
// Synchronous FIFO controller for a simple dual-port BRAM with a prefetch buffer hiding the read latency.
// Optional `BRAM_FIFO_LEVEL_EN adds the registered level and almost_full outputs.
module bram_fifo_ctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int OREG  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic [DW-1:0]              m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       bram_wea,
    output logic [$clog2(DEPTH)-1:0]   bram_addra,
    output logic [DW-1:0]              bram_dina,
    output logic                       bram_enb,
    output logic [$clog2(DEPTH)-1:0]   bram_addrb,
    output logic                       bram_regceb,
    input  logic [DW-1:0]              bram_doutb
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH)+1:0]   level,
    output logic                       almost_full
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LAT = (OREG != 0) ? 2 : 1;
    localparam int PF  = LAT + 1;

    logic [AW:0]     wr_ptr, rd_ptr, stored;
    logic [LAT-1:0]  vpipe;
    logic [DW-1:0]   pf_mem [4];
    logic [1:0]      pf_wp, pf_rp;
    logic [2:0]      pf_cnt, inflight, occ;
    logic            wr_fire, rd_en, push, pop, empty, full;

    function automatic logic [1:0] pf_next(input logic [1:0] p);
        return (p == 2'(PF - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // NOTE: combinational logic uses blocking '=' with every output assigned up front; clocked state uses '<='.
    always_comb begin
        stored   = wr_ptr - rd_ptr;
        // stored never exceeds DEPTH, so its MSB alone marks full
        full     = stored[AW];
        empty    = (stored == '0);
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + 3'(vpipe[i]);
        end
        push     = vpipe[LAT-1];
        s_tready = !rst && !full;
        m_tvalid = !rst && (pf_cnt != 3'd0);
        m_tdata  = pf_mem[pf_rp];
        wr_fire  = s_tvalid && s_tready;
        pop      = m_tvalid && m_tready;
        // a read is issued only if its data is guaranteed a free prefetch slot on return
        occ      = inflight + pf_cnt - 3'(pop);
        rd_en    = !rst && !empty && (occ < 3'(PF));

        bram_wea    = wr_fire;
        bram_addra  = wr_ptr[AW-1:0];
        bram_dina   = s_tdata;
        bram_enb    = rd_en;
        bram_addrb  = rd_ptr[AW-1:0];
        bram_regceb = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vpipe  <= '0;
            pf_wp  <= '0;
            pf_rp  <= '0;
            pf_cnt <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en)   rd_ptr <= rd_ptr + (AW+1)'(1);
            vpipe <= LAT'({vpipe, rd_en});
            if (push) pf_wp <= pf_next(pf_wp);
            if (pop)  pf_rp <= pf_next(pf_rp);
            pf_cnt <= pf_cnt + 3'(push) - 3'(pop);
        end
    end

    // NOTE: prefetch storage has no reset; pf_cnt alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) pf_mem[pf_wp] <= bram_doutb;
    end

`ifdef BRAM_FIFO_LEVEL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= (AW+2)'(stored) + (AW+2)'(inflight) + (AW+2)'(pf_cnt);
            almost_full <= (stored >= (AW+1)'(DEPTH - 4));
        end
    end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl: one OREG=1 and one OREG=0 instance, DEPTH=16, DW=16,
// each attached to a behavioural BRAM model.
module tb_bram_fifo_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        m_tready;

    logic        s_tready0, m_tvalid0, wea0, enb0, regceb0;
    logic [15:0] m_tdata0, dina0, doutb0;
    logic [3:0]  addra0, addrb0;
    logic        s_tready1, m_tvalid1, wea1, enb1, regceb1;
    logic [15:0] m_tdata1, dina1, doutb1;
    logic [3:0]  addra1, addrb1;
`ifdef BRAM_FIFO_LEVEL_EN
    logic [5:0]  level0, level1;
    logic        af0, af1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] got0[$];
    logic [15:0] got1[$];
    int          gc0[$];
    int          gc1[$];
    logic [3:0]  exp_a, exp_b;
    int          addr_err, wrap_a, wrap_b;

    bram_fifo_ctrl #(.DW(16), .DEPTH(16), .OREG(1)) dut0 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready0),
        .m_tdata(m_tdata0), .m_tvalid(m_tvalid0), .m_tready(m_tready),
        .bram_wea(wea0), .bram_addra(addra0), .bram_dina(dina0),
        .bram_enb(enb0), .bram_addrb(addrb0), .bram_regceb(regceb0),
        .bram_doutb(doutb0)
`ifdef BRAM_FIFO_LEVEL_EN
        , .level(level0), .almost_full(af0)
`endif
    );

    bram_fifo_ctrl #(.DW(16), .DEPTH(16), .OREG(0)) dut1 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready1),
        .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(m_tready),
        .bram_wea(wea1), .bram_addra(addra1), .bram_dina(dina1),
        .bram_enb(enb1), .bram_addrb(addrb1), .bram_regceb(regceb1),
        .bram_doutb(doutb1)
`ifdef BRAM_FIFO_LEVEL_EN
        , .level(level1), .almost_full(af1)
`endif
    );

    // BRAM models: two-cycle read with output register, and one-cycle read
    logic [15:0] mem0 [16];
    logic [15:0] mem1 [16];
    logic [15:0] r0a, r0b, r1a;

    always @(posedge clk) begin
        if (wea0) mem0[addra0] <= dina0;
        if (enb0) r0a <= mem0[addrb0];
        if (regceb0) r0b <= r0a;
        if (wea1) mem1[addra1] <= dina1;
        if (enb1) r1a <= mem1[addrb1];
    end
    assign doutb0 = r0b;
    assign doutb1 = r1a;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output capture and BRAM address sequence model, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_a = '0;
            exp_b = '0;
        end else begin
            if (m_tvalid0 && m_tready) begin got0.push_back(m_tdata0); gc0.push_back(cyc); end
            if (m_tvalid1 && m_tready) begin got1.push_back(m_tdata1); gc1.push_back(cyc); end
            if (wea0) begin
                if (addra0 !== exp_a) addr_err++;
                if (exp_a == 4'd15) wrap_a++;
                exp_a = exp_a + 4'd1;
            end
            if (enb0) begin
                if (addrb0 !== exp_b) addr_err++;
                if (exp_b == 4'd15) wrap_b++;
                exp_b = exp_b + 4'd1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
        got0.delete(); got1.delete(); gc0.delete(); gc1.delete();
    endtask

    // Offer n consecutive words base+k, holding each until dut0 accepts it
    task automatic push_seq(input int n, input logic [15:0] base);
        int k = 0;
        int t = 0;
        s_tvalid = 1'b1;
        while (k < n && t < 200) begin
            s_tdata = 16'(base + 16'(k));
            @(negedge clk);
            if (s_tready0) k++;
            next_cyc();
            t++;
        end
        s_tvalid = 1'b0;
        check("push_count", 32'(k), 32'(n));
    endtask

    initial begin
        int c0, i, t, bad;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        addr_err = 0; wrap_a = 0; wrap_b = 0;

        // Reset state
        next_cyc();
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_tvalid0), 32'd0);
        check("rst_s_tready", 32'(s_tready0), 32'd0);
        check("rst_wea", 32'(wea0), 32'd0);
        check("rst_enb", 32'(enb0), 32'd0);
        check("regceb", 32'(regceb0), 32'd1);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        check("s_tready_after_rst", 32'(s_tready0), 32'd1);
        check("s_tready_after_rst_oreg0", 32'(s_tready1), 32'd1);
        next_cyc();

        // Latency and back-to-back streaming, both read latencies
        m_tready = 1'b1;
        c0 = cyc;
        push_seq(5, 16'h0001);
        repeat (10) next_cyc();
        check("oreg1_count", 32'(got0.size()), 32'd5);
        check("oreg0_count", 32'(got1.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("oreg1_data", (k < got0.size()) ? 32'(got0[k]) : 32'hDEAD, 32'(k + 1));
            check("oreg0_data", (k < got1.size()) ? 32'(got1[k]) : 32'hDEAD, 32'(k + 1));
        end
        check("oreg1_latency", (gc0.size() > 0) ? 32'(gc0[0] - c0) : 32'hDEAD, 32'd4);
        check("oreg0_latency", (gc1.size() > 0) ? 32'(gc1[0] - c0) : 32'hDEAD, 32'd3);
        check("oreg1_no_gap", (gc0.size() == 5) ? 32'(gc0[4] - gc0[0]) : 32'hDEAD, 32'd4);
        check("oreg0_no_gap", (gc1.size() == 5) ? 32'(gc1[4] - gc1[0]) : 32'hDEAD, 32'd4);

        // Fill with the sink stalled: 16 in BRAM plus 3 prefetched
        do_reset();
        i = 0;
        s_tvalid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            s_tdata = 16'(16'h0100 + 16'(i));
            @(negedge clk);
            if (s_tready0) i++;
            next_cyc();
        end
        s_tdata = 16'(16'h0100 + 16'(i));
        @(negedge clk);
        check("full_accepted", 32'(i), 32'd19);
        check("full_s_tready", 32'(s_tready0), 32'd0);
        check("full_enb", 32'(enb0), 32'd0);
        next_cyc();
        m_tready = 1'b1;
        @(negedge clk);
        check("drain_first_issue", 32'(enb0), 32'd1);
        check("drain_s_tready_same", 32'(s_tready0), 32'd0);
        next_cyc();
        @(negedge clk);
        check("drain_s_tready_next", 32'(s_tready0), 32'd1);
        if (s_tready0) i++;
        next_cyc();
        s_tvalid = 1'b0;
        repeat (40) next_cyc();
        check("drain_count", 32'(got0.size()), 32'd20);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (k >= got0.size() || got0[k] !== 16'(16'h0100 + 16'(k))) bad++;
        end
        check("drain_order", 32'(bad), 32'd0);

        // Random handshakes across several pointer wraps
        do_reset();
        addr_err = 0; wrap_a = 0; wrap_b = 0;
        i = 0;
        t = 0;
        while (got0.size() < 100 && t < 3000) begin
            s_tvalid = (i < 100) && ($urandom_range(0, 3) != 0);
            s_tdata  = 16'(16'h2000 + 16'(i));
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (s_tvalid && s_tready0) i++;
            next_cyc();
            t++;
        end
        s_tvalid = 1'b0;
        check("rand_count", 32'(got0.size()), 32'd100);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (k >= got0.size() || got0[k] !== 16'(16'h2000 + 16'(k))) bad++;
        end
        check("rand_order", 32'(bad), 32'd0);
        check("addr_sequence", 32'(addr_err), 32'd0);
        check("addra_wrapped", 32'(wrap_a >= 5), 32'd1);
        check("addrb_wrapped", 32'(wrap_b >= 5), 32'd1);

        // Reset mid-stream with words buffered and reads in flight
        do_reset();
        push_seq(6, 16'h5000);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_m_tvalid", 32'(m_tvalid0), 32'd0);
        check("midrst_s_tready", 32'(s_tready0), 32'd0);
        check("midrst_wea", 32'(wea0), 32'd0);
        check("midrst_enb", 32'(enb0), 32'd0);
        next_cyc();
        rst = 1'b0;
        got0.delete(); gc0.delete();
        @(negedge clk);
        check("postrst_m_tvalid", 32'(m_tvalid0), 32'd0);
        check("postrst_s_tready", 32'(s_tready0), 32'd1);
        check("postrst_enb", 32'(enb0), 32'd0);
        next_cyc();
        m_tready = 1'b1;
        push_seq(1, 16'hAAAA);
        repeat (10) next_cyc();
        check("postrst_count", 32'(got0.size()), 32'd1);
        check("postrst_data", (got0.size() > 0) ? 32'(got0[0]) : 32'hDEAD, 32'h0000AAAA);

`ifdef BRAM_FIFO_LEVEL_EN
        // Occupancy outputs with the sink stalled: 13 stored + 3 prefetched
        do_reset();
        push_seq(16, 16'h0300);
        repeat (6) next_cyc();
        @(negedge clk);
        check("level", 32'(level0), 32'd16);
        check("almost_full", 32'(af0), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
